load_store_unit: RTL and testbench

Sits between the pipeline's MEM stage and `data_memory` and owns every data access. It checks alignment, issues word-aligned reads and byte/half/word stores, and waits a fixed number of cycles for the memory. It then sign- or zero-extends load data and stalls the pipeline for the duration of each access.

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit_load_extend.sv | 33 +++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-type codes, FSM states
// and the alignment rule used to qualify MEM-stage requests.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } lsu_state_t;

    // Unknown access codes are reported as not aligned so one test covers
    // both the legality and the alignment of a request.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic ok;
        case (funct3)
            LB, LBU: ok = 1'b1;
            LH, LHU: ok = ~offset[0];
            LW:      ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half/word out of a memory word and extends it.
// Lane [31:24] carries the byte at the word address, [7:0] the byte at +3.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic        [7:0]  lane [4];
    logic signed [7:0]  sel_byte;
    logic signed [15:0] sel_half;

    // Split the word into per-address bytes, select the operand and extend it
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = word[31-8*i -: 8];
        end
        sel_byte = lane[offset];
        sel_half = {lane[{offset[1], 1'b1}], lane[{offset[1], 1'b0}]};
        case (funct3)
            LB:      result = 32'(sel_byte);
            LH:      result = 32'(sel_half);
            LBU:     result = {24'd0, sel_byte};
            LHU:     result = {16'd0, sel_half};
            LW:      result = {lane[3], lane[2], lane[1], lane[0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and data memory. Qualifies each
// request, drives fixed-latency memory strobes, extends load data and
// stalls the pipeline while an access is in flight.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY  = 5,
    parameter int WRITE_LATENCY = 1
)(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] STORE_DATA,
    output logic [31:0] LOAD_DATA,
    output logic        STALL,
    output logic        FAULT,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [2:0]  DM_FUNCT3,
    output logic [31:0] DM_ADDRESS,
    output logic [31:0] DM_WRITEDATA,
    input  logic [31:0] DM_READDATA
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_LATENCY - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] lat_cnt;
    logic [1:0]       ld_offset;
    logic [2:0]       ld_funct3;
    logic [31:0]      extended;
    logic             load_ok;
    logic             store_ok;

    // Classify the request and decode stall/fault; both held low during reset
    always_comb begin
        load_ok  = MEM_READ & ~MEM_WRITE & is_aligned(FUNCT3, ADDRESS[1:0]);
        store_ok = MEM_WRITE & ~MEM_READ & ~FUNCT3[2] & is_aligned(FUNCT3, ADDRESS[1:0]);
        STALL    = 1'b0;
        FAULT    = 1'b0;
        if (RESET_N) begin
            case (state)
                IDLE: begin
                    STALL = load_ok | store_ok;
                    FAULT = (MEM_READ | MEM_WRITE) & ~(load_ok | store_ok);
                end
                RD_WAIT, WR_WAIT: STALL = 1'b1;
                default: ;
            endcase
        end
    end

    // Access FSM with latency counter and registered memory-side outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            DM_READ      <= 1'b0;
            DM_WRITE     <= 1'b0;
            DM_FUNCT3    <= '0;
            DM_ADDRESS   <= '0;
            DM_WRITEDATA <= '0;
            LOAD_DATA    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    if (load_ok) begin
                        DM_ADDRESS <= {ADDRESS[31:2], 2'b00};
                        DM_READ    <= 1'b1;
                        state      <= RD_WAIT;
                    end else if (store_ok) begin
                        DM_ADDRESS   <= ADDRESS;
                        DM_WRITEDATA <= STORE_DATA;
                        DM_FUNCT3    <= FUNCT3;
                        DM_WRITE     <= 1'b1;
                        state        <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == RD_LAST) begin
                        LOAD_DATA <= extended;
                        DM_READ   <= 1'b0;
                        state     <= DONE;
                    end
                end
                WR_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == WR_LAST) begin
                        DM_WRITE <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    // The request still visible here belongs to the finished access
                    lat_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Remember the load's byte offset and type for extraction at completion
    always_ff @(posedge CLK) begin
        if (state == IDLE && load_ok) begin
            ld_offset <= ADDRESS[1:0];
            ld_funct3 <= FUNCT3;
        end
    end

    load_extend u_extend (
        .word   (DM_READDATA),
        .offset (ld_offset),
        .funct3 (ld_funct3),
        .result (extended)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus hand-written
// reset-abort and back-to-back sequences, with a byte-array data memory.
module tb_load_store_unit;

    localparam int RL = 5;
    localparam int WL = 1;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS, STORE_DATA;
    logic [31:0] LOAD_DATA;
    logic        STALL, FAULT, DM_READ, DM_WRITE;
    logic [2:0]  DM_FUNCT3;
    logic [31:0] DM_ADDRESS, DM_WRITEDATA, DM_READDATA;

    load_store_unit #(.READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .STORE_DATA(STORE_DATA),
        .LOAD_DATA(LOAD_DATA), .STALL(STALL), .FAULT(FAULT),
        .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_FUNCT3(DM_FUNCT3),
        .DM_ADDRESS(DM_ADDRESS), .DM_WRITEDATA(DM_WRITEDATA), .DM_READDATA(DM_READDATA)
    );

    always #5 CLK = ~CLK;

    // ---------------- data memory model ----------------
    logic [7:0] mem [512];
    logic [7:0] exp_mem [512];
    logic [8:0] mem_a;
    logic       init_req;

    always_comb begin
        mem_a       = DM_ADDRESS[8:0];
        DM_READDATA = {mem[mem_a], mem[mem_a + 9'd1], mem[mem_a + 9'd2], mem[mem_a + 9'd3]};
    end

    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[9'h10] <= 8'h11;
            mem[9'h11] <= 8'h22;
            mem[9'h12] <= 8'h33;
            mem[9'h13] <= 8'h44;
        end else if (DM_WRITE) begin
            case (DM_FUNCT3)
                3'b000: mem[mem_a] <= DM_WRITEDATA[7:0];
                3'b001: begin
                    mem[mem_a]        <= DM_WRITEDATA[7:0];
                    mem[mem_a + 9'd1] <= DM_WRITEDATA[15:8];
                end
                default: for (int i = 0; i < 4; i++) mem[mem_a + 9'(i)] <= DM_WRITEDATA[8*i +: 8];
            endcase
        end
    end

    // Count access starts (rising strobes)
    int   rd_starts = 0;
    int   wr_starts = 0;
    logic rd_prev = 1'b0;
    logic wr_prev = 1'b0;
    always @(negedge CLK) begin
        if (DM_READ && !rd_prev) rd_starts <= rd_starts + 1;
        if (DM_WRITE && !wr_prev) wr_starts <= wr_starts + 1;
        rd_prev <= DM_READ;
        wr_prev <= DM_WRITE;
    end

    // ---------------- reference model and checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q [$];
    logic [31:0] last_load;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [8:0]  p;
        logic [31:0] r;
        p = a[8:0];
        case (f3)
            3'b000:  r = {{24{exp_mem[p][7]}}, exp_mem[p]};
            3'b100:  r = {24'd0, exp_mem[p]};
            3'b001:  r = {{16{exp_mem[p + 9'd1][7]}}, exp_mem[p + 9'd1], exp_mem[p]};
            3'b101:  r = {16'd0, exp_mem[p + 9'd1], exp_mem[p]};
            default: r = {exp_mem[p + 9'd3], exp_mem[p + 9'd2], exp_mem[p + 9'd1], exp_mem[p]};
        endcase
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        logic [8:0] p;
        p = a[8:0];
        exp_mem[p] = d[7:0];
        if (f3 != 3'b000) exp_mem[p + 9'd1] = d[15:8];
        if (f3 == 3'b010) begin
            exp_mem[p + 9'd2] = d[23:16];
            exp_mem[p + 9'd3] = d[31:24];
        end
    endtask

    // Drive one request at a negedge and follow it until STALL drops
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd, input bit hold,
                              output int stall_n, output int rd_n, output int wr_n,
                              output logic fault_0);
        @(negedge CLK);
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = addr; STORE_DATA = sd;
        #1;
        fault_0 = FAULT;
        stall_n = 0; rd_n = 0; wr_n = 0;
        while (STALL && stall_n < 64) begin
            stall_n++;
            @(negedge CLK); #1;
            if (DM_READ) rd_n++;
            if (DM_WRITE) wr_n++;
        end
        if (stall_n >= 64) begin
            n_checks++; n_errors++;
            $display("FAIL stall_bound: STALL still high after %0d cycles, required release", stall_n);
        end
        if (!hold) begin
            MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic        exp_fault;
        int          exp_stall;
        logic        chk;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [20];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   s_n, r_n, w_n, rs0, ws0;
        logic f0;
        logic [31:0] e;

        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, RL+1, 1'b1, 32'h44332211};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h13,  32'h12345680, 1'b0, WL+1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h13,  32'h0,        1'b0, RL+1, 1'b1, 32'hFFFFFF80};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h13,  32'h0,        1'b0, RL+1, 1'b1, 32'h00000080};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h22,  32'hABCD1234, 1'b0, WL+1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h22,  32'h0,        1'b0, RL+1, 1'b1, 32'h00001234};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        1'b0, RL+1, 1'b1, 32'h12347B7A};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h30,  32'h00008001, 1'b0, WL+1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h30,  32'h0,        1'b0, RL+1, 1'b1, 32'hFFFF8001};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 0,    1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h40,  32'h0,        1'b1, 0,    1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h40,  32'h0,        1'b1, 0,    1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h40,  32'h0,        1'b1, 0,    1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h21,  32'h0,        1'b1, 0,    1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h40,  32'hDEADBEEF, 1'b0, WL+1, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h40,  32'h0,        1'b0, RL+1, 1'b1, 32'hDEADBEEF};
        vecs[16] = '{1'b1, 1'b0, 3'b000, 32'h41,  32'h0,        1'b0, RL+1, 1'b1, 32'hFFFFFFBE};
        vecs[17] = '{1'b1, 1'b0, 3'b101, 32'h42,  32'h0,        1'b0, RL+1, 1'b1, 32'h0000DEAD};
        vecs[18] = '{1'b0, 1'b1, 3'b010, 32'h46,  32'h0,        1'b1, 0,    1'b0, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 3'b111, 32'h40,  32'h0,        1'b1, 0,    1'b0, 32'h0};

        RESET_N = 1'b0; init_req = 1'b1;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNCT3 = 3'b000; ADDRESS = '0; STORE_DATA = '0;
        for (int i = 0; i < 512; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
        exp_mem[9'h10] = 8'h11; exp_mem[9'h11] = 8'h22;
        exp_mem[9'h12] = 8'h33; exp_mem[9'h13] = 8'h44;
        last_load = '0;

        // Reset state
        @(negedge CLK); #1;
        check("rst_load_data", LOAD_DATA, 32'h0);
        check("rst_stall", {31'd0, STALL}, 32'h0);
        check("rst_fault", {31'd0, FAULT}, 32'h0);
        check("rst_strobes", {30'd0, DM_READ, DM_WRITE}, 32'h0);
        check("rst_dm_addr", DM_ADDRESS, 32'h0);
        check("rst_dm_wdata", DM_WRITEDATA, 32'h0);
        check("rst_dm_funct3", {29'd0, DM_FUNCT3}, 32'h0);
        MEM_READ = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h10; #1;
        check("rst_stall_req", {31'd0, STALL}, 32'h0);
        ADDRESS = 32'h102; #1;
        check("rst_fault_req", {31'd0, FAULT}, 32'h0);
        MEM_READ = 1'b0;
        @(negedge CLK);
        init_req = 1'b0; RESET_N = 1'b1;

        // Vector table
        for (int k = 0; k < 20; k++) begin
            logic is_ld, is_st;
            is_ld = vecs[k].rd && !vecs[k].exp_fault;
            is_st = vecs[k].wr && !vecs[k].exp_fault;
            if (is_ld) begin
                e = ref_load(vecs[k].addr, vecs[k].f3);
                sb_q.push_back(e);
                last_load = e;
            end
            if (is_st) ref_store(vecs[k].addr, vecs[k].f3, vecs[k].sd);
            run_access(vecs[k].rd, vecs[k].wr, vecs[k].f3, vecs[k].addr, vecs[k].sd, 1'b0,
                       s_n, r_n, w_n, f0);
            check($sformatf("v%0d_fault", k), {31'd0, f0}, {31'd0, vecs[k].exp_fault});
            check($sformatf("v%0d_stall", k), s_n, vecs[k].exp_stall);
            check($sformatf("v%0d_rd_cycles", k), r_n, is_ld ? RL : 0);
            check($sformatf("v%0d_wr_cycles", k), w_n, is_st ? WL : 0);
            if (is_ld) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL v%0d_scoreboard: queue empty, required one entry", k);
                end else begin
                    check($sformatf("v%0d_sb_data", k), LOAD_DATA, sb_q.pop_front());
                end
                if (vecs[k].chk) check($sformatf("v%0d_data", k), LOAD_DATA, vecs[k].exp_data);
            end else begin
                check($sformatf("v%0d_data_hold", k), LOAD_DATA, last_load);
            end
        end

        // Half store touches only its two bytes
        check("mem_20", {24'd0, mem[9'h20]}, 32'h7A);
        check("mem_21", {24'd0, mem[9'h21]}, 32'h7B);
        check("mem_22", {24'd0, mem[9'h22]}, 32'h34);
        check("mem_23", {24'd0, mem[9'h23]}, 32'h12);
        check("mem_24", {24'd0, mem[9'h24]}, 32'h7E);

        // Reset in the third RD_WAIT cycle
        @(negedge CLK);
        MEM_READ = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h10;
        repeat (3) @(negedge CLK);
        #1;
        check("abort_pre_dm_read", {31'd0, DM_READ}, 32'h1);
        RESET_N = 1'b0;
        #1;
        check("abort_dm_read", {31'd0, DM_READ}, 32'h0);
        check("abort_stall", {31'd0, STALL}, 32'h0);
        check("abort_load_data", LOAD_DATA, 32'h0);
        MEM_READ = 1'b0;
        last_load = '0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        e = ref_load(32'h40, 3'b010);
        sb_q.push_back(e);
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, s_n, r_n, w_n, f0);
        check("post_abort_stall", s_n, RL + 1);
        check("post_abort_data", LOAD_DATA, sb_q.pop_front());

        // Back-to-back SW then LW, each request held through DONE
        #1;
        rs0 = rd_starts; ws0 = wr_starts;
        ref_store(32'h50, 3'b010, 32'hCAFEF00D);
        run_access(1'b0, 1'b1, 3'b010, 32'h50, 32'hCAFEF00D, 1'b1, s_n, r_n, w_n, f0);
        check("b2b_sw_stall", s_n, WL + 1);
        e = ref_load(32'h50, 3'b010);
        sb_q.push_back(e);
        run_access(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 1'b1, s_n, r_n, w_n, f0);
        check("b2b_lw_stall", s_n, RL + 1);
        check("b2b_lw_data", LOAD_DATA, sb_q.pop_front());
        check("b2b_lw_const", LOAD_DATA, 32'hCAFEF00D);
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("b2b_reads", rd_starts - rs0, 1);
        check("b2b_writes", wr_starts - ws0, 1);

        // Whole memory against the store model
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 512; i++) if (mem[i] !== exp_mem[i]) bad++;
            check("mem_sweep_bad_bytes", bad, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
